// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, oversampled bit timing, fixed
// 8E1-style framing (start, DATA bits LSB first, even parity, stop).
module uart_rx #(
  parameter int unsigned DATA         = 8,
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_in,
  output logic [DATA-1:0] rx_data,
  output logic            rx_valid,
  output logic            rx_parity_err,
  output logic            rx_frame_err,
  output logic            rx_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = (DATA > 1) ? $clog2(DATA) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q;
  logic            rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DATA-1:0] shift_q, shift_d;
  logic            par_err_q, par_err_d;
  logic [DATA-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= rx_in;
      rx_s_q    <= sync1_q;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end

      // A start bit that is high again at its centre is a glitch.
      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA-1:1]};
          if (idx_q == IDX_LAST) state_d = S_PARITY;
          else                   idx_d   = idx_q + IW'(1);
        end
      end

      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_err_d = rx_s_q ^ (^shift_q);
          state_d   = S_STOP;
        end
      end

      // Leaving mid-stop-bit lets a back-to-back start edge be caught.
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          data_d  = shift_q;
          perr_d  = par_err_q;
          ferr_d  = ~rx_s_q;
          valid_d = 1'b1;
          state_d = rx_s_q ? S_IDLE : S_BREAK;
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, glitch/reset
// sequences and random frames checked against a frame-level model.
module tb_uart_rx;

  localparam int unsigned DATA = 8;
  localparam int unsigned CPB  = 16;

  logic            clk;
  logic            reset;
  logic            rx_in;
  logic [DATA-1:0] rx_data;
  logic            rx_valid;
  logic            rx_parity_err;
  logic            rx_frame_err;
  logic            rx_busy;

  uart_rx #(.DATA(DATA), .CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_in         (rx_in),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_busy       (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic        par_bit;
    logic        stop_bit;
    int unsigned hold_low;
    logic        idle_chk;
    logic [7:0]  exp_data;
    logic        exp_perr;
    logic        exp_ferr;
  } vec_t;

  exp_t expq[$];
  int   errors    = 0;
  int   checks    = 0;
  int   valid_cnt = 0;
  int   pushed    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    expq.push_back(e);
    pushed++;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && rx_valid === 1'b1) begin
      valid_cnt++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0 data=%0h", rx_data);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.data));
        chk("rx_parity_err", 32'(rx_parity_err), 32'(e.perr));
        chk("rx_frame_err", 32'(rx_frame_err), 32'(e.ferr));
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int unsigned hold_low);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
    if (hold_low > 0) begin
      rx_in = 1'b0;
      repeat (hold_low) @(negedge clk);
      chk("busy_in_break", 32'(rx_busy), 32'd1);
      rx_in = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
  endtask

  task automatic wait_drain;
    for (int i = 0; i < 64 && expq.size() != 0; i++) @(negedge clk);
    chk("pending_frames", 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 0,  1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h01, 1'b0, 1'b1, 0,  1'b1, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{8'h03, 1'b0, 1'b1, 0,  1'b1, 8'h03, 1'b0, 1'b0};
    tbl[3] = '{8'h5A, 1'b0, 1'b1, 0,  1'b1, 8'h5A, 1'b0, 1'b0};
    tbl[4] = '{8'h7E, 1'b0, 1'b0, 40, 1'b1, 8'h7E, 1'b0, 1'b1};
    tbl[5] = '{8'h81, 1'b0, 1'b1, 0,  1'b1, 8'h81, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 1'b0, 1'b1, 0,  1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{8'hFF, 1'b0, 1'b1, 0,  1'b1, 8'hFF, 1'b0, 1'b0};

    reset = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_parity_err", 32'(rx_parity_err), 32'd0);
    chk("reset_frame_err", 32'(rx_frame_err), 32'd0);
    chk("reset_rx_busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        // Short low pulse: must be rejected as a false start.
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy", 32'(rx_busy), 32'd1);
        rx_in = 1'b1;
        repeat (24) @(negedge clk);
        chk("glitch_idle", 32'(rx_busy), 32'd0);
        chk("glitch_data_kept", 32'(rx_data), 32'h03);
        chk("glitch_perr_kept", 32'(rx_parity_err), 32'd0);
        chk("glitch_no_valid", 32'(valid_cnt), 32'(pushed));
      end
      push_exp(tbl[i].exp_data, tbl[i].exp_perr, tbl[i].exp_ferr);
      send_frame(tbl[i].data, tbl[i].par_bit, tbl[i].stop_bit, tbl[i].hold_low);
      if (tbl[i].idle_chk) begin
        wait_drain();
        repeat (2) @(negedge clk);
        chk("busy_after_frame", 32'(rx_busy), 32'd0);
      end
    end
    chk("table_valid_count", 32'(valid_cnt), 32'(pushed));

    // Reset in the middle of data bit 4 of a frame carrying 0x96.
    begin
      logic [7:0] part;
      part = 8'h96;
      drive_bit(1'b0);
      for (int b = 0; b < 4; b++) drive_bit(part[b]);
      rx_in = part[4];
      repeat (CPB / 2) @(negedge clk);
      chk("busy_before_abort", 32'(rx_busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_rx_data", 32'(rx_data), 32'd0);
      chk("abort_rx_valid", 32'(rx_valid), 32'd0);
      chk("abort_parity_err", 32'(rx_parity_err), 32'd0);
      chk("abort_frame_err", 32'(rx_frame_err), 32'd0);
      chk("abort_rx_busy", 32'(rx_busy), 32'd0);
      rx_in = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("abort_no_valid", 32'(valid_cnt), 32'(pushed));
      chk("abort_idle", 32'(rx_busy), 32'd0);
      push_exp(8'hC3, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b0, 1'b1, 0);
      wait_drain();
    end

    // Random frames judged by the frame-level rules.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       p;
      logic       s;
      int unsigned hold;
      d    = 8'($urandom);
      p    = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      s    = ($urandom_range(0, 5) != 0);
      hold = s ? 0 : $urandom_range(1, 30);
      push_exp(d, p != (^d), ~s);
      send_frame(d, p, s, hold);
      if (s) begin
        rx_in = 1'b1;
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
    end
    wait_drain();
    repeat (4) @(negedge clk);
    chk("final_valid_count", 32'(valid_cnt), 32'(pushed));
    chk("final_idle", 32'(rx_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side stage: consumes the serial line driven by the UART transmitter, recovers one frame and presents the parallel byte with status flags.
- Frame format is fixed: 1 start bit (0), DATA data bits LSB first, 1 even-parity bit (XOR of data bits), 1 stop bit (1).
- Bit timing is generated internally by oversampling against clk, because receiver phase cannot be shared with the transmitter's tick.
- Sits between the serial pin (or a loopback of tx_out) and the consuming logic.

Parameters:
- DATA, 8, number of data bits per frame.
- CLKS_PER_BIT, 5208, clk cycles per bit period. Must be ≥ 4. The bench overrides it to 16.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA  last received data word.
- rx_valid  output  1  one-cycle pulse: frame complete, rx_data and error flags updated.
- rx_parity_err  output  1  parity bit mismatched for the last frame.
- rx_frame_err  output  1  stop bit sampled 0 for the last frame.
- rx_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (at clk edge while reset=1):
  - state=IDLE; synchronizer flops=1; counters=0.
  - rx_data=0, rx_valid=0, rx_parity_err=0, rx_frame_err=0, rx_busy=0.
- Reset overrides everything, including mid-frame. After reset the block re-hunts for a start bit and discards any partial frame.
- Input synchronizer:
  - 2-flop synchronizer on rx_in. All decisions use the second flop (rx_s).
  - Fixed 2-cycle input latency.
- Bit counter cnt runs 0..CLKS_PER_BIT-1 and is cleared on every state entry. Data index bit_idx runs 0..DATA-1.
- States:
  - IDLE: rx_busy=0. When rx_s==0 -> START, cnt=0.
  - START: when cnt==CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
    - rx_s==0 -> DATA, cnt=0, bit_idx=0.
    - rx_s==1 -> false start (glitch) -> IDLE. No rx_valid, flags unchanged.
  - DATA: when cnt==CLKS_PER_BIT-1, sample rx_s and shift it into the MSB of a DATA-bit shift register (right shift), giving LSB-first assembly. cnt=0.
    - bit_idx==DATA-1 -> PARITY; otherwise bit_idx+1.
  - PARITY: when cnt==CLKS_PER_BIT-1, latch par_err = rx_s XOR (^shift_reg). -> STOP, cnt=0.
  - STOP: when cnt==CLKS_PER_BIT-1, sample rx_s. On the next clk edge:
    - rx_data<=shift_reg, rx_parity_err<=par_err, rx_frame_err<=~rx_s, rx_valid<=1.
    - rx_s==1 -> IDLE; rx_s==0 -> BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE. Prevents a held-low line from being read as a new start bit.
- rx_valid:
  - Exactly one clk cycle per completed frame, including frames with errors.
  - Not asserted for false starts.
  - No back-pressure: the consumer must take rx_data in that cycle.
- rx_data and both error flags hold their values until the next rx_valid.
- Latency: rx_valid rises one clk after the mid-stop-bit sample, i.e. about (DATA+2.5)*CLKS_PER_BIT + 3 clks after the line falling edge at rx_in.
- Back-to-back frames: a start edge immediately after the stop bit is accepted, because IDLE is re-entered mid-stop bit.
- All sampling is single-point at the bit centre. There is no majority vote.

Test Plan:
- CLKS_PER_BIT=16. Drive frame 0xA5 with parity 0 and stop 1 -> one rx_valid pulse; rx_data=0xA5, rx_parity_err=0, rx_frame_err=0; rx_busy low afterwards.
- Drive data 0x01 with parity bit 0 (wrong) -> rx_valid pulse; rx_data=0x01, rx_parity_err=1, rx_frame_err=0. Follow with 0x03 and parity 0 -> rx_parity_err returns to 0.
- Pull rx_in low for 4 clks, then high -> no rx_valid, state back to IDLE, flags unchanged. Then a valid frame 0x5A (parity 0) -> rx_data=0x5A.
- Frame 0x7E with stop bit 0, line held low 40 clks, then high -> single rx_valid with rx_frame_err=1, rx_data=0x7E. No second frame is decoded during the low period; the next 0x81 (parity 0) is received correctly.
- Back-to-back 0x00 (parity 0) then 0xFF (parity 0) with no idle gap -> two rx_valid pulses, rx_data 0x00 then 0xFF, both error-free.
- Assert reset for 1 clk mid-data-bit-4 of a frame -> all outputs 0 the next cycle, no rx_valid for the aborted frame; after the line idles high, the next frame 0xC3 (parity 0) is received correctly.
